hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage RV64 core: decides every cycle whether the IF/ID and ID/EX pipeline registers advance, stall or flush, and selects EX-stage operand forwarding. It keeps its own shadow scoreboard of the in-flight EX, MEM and WB instructions, so the datapath only supplies decode-stage fields and the branch outcome. It drives the PC write enable, the IF/ID write/flush inputs and the ID/EX bubble input, and it exposes stall and flush performance counters.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: single core clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: the IF/ID register holds a real instruction.
- `id_rs1`, `id_rs2` in 5: source registers of the ID instruction (`instruction[19:15]`, `instruction[24:20]`).
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads rs1 / rs2.
- `id_rd` in 5: destination register of the ID instruction.
- `id_reg_write`, `id_mem_read` in 1: control-unit decode of the ID instruction.
- `ex_branch_taken` in 1: `branch & zero` of the instruction currently in EX.
- `pc_write` out 1: PC loads its next value.
- `if_id_write` out 1: IF/ID captures a new instruction.
- `if_id_flush` out 1: IF/ID loads a NOP.
- `id_ex_bubble` out 1: ID/EX loads zeroed control (a bubble).
- `fwd_a`, `fwd_b` out 2: EX operand select: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write-back data.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating counters.

## Operation
- Scoreboard: three entries `sb_ex`, `sb_mem`, `sb_wb`. Each entry is {valid, rd, rs1, rs2, use_rs1, use_rs2, reg_write, mem_read}. The entries shift every cycle:
  - `sb_wb` ← `sb_mem`
  - `sb_mem` ← `sb_ex`
  - `sb_ex` ← the ID fields, or an invalid entry when `id_ex_bubble`=1.
- Match rule: a producer entry matches a source register only if valid, reg_write=1, rd≠0, and rd equals the source register with the corresponding use bit set. Register x0 never causes a hazard and is never forwarded.
- Load-use hazard (forwarding on): the ID instruction matches `sb_ex` and `sb_ex.mem_read`=1. Response: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1. This lasts 1 cycle.
- Forwarding, evaluated on `sb_ex`'s rs1/rs2:
  - Select 10 if `sb_mem` matches.
  - Else select 01 if `sb_wb` matches.
  - Else select 00.
  - When both match, MEM (the youngest producer) wins.
- Branch taken: `if_id_flush`=1 and `id_ex_bubble`=1, while `pc_write`=1 so the PC loads the target. The branch has priority over any simultaneous stall; the stall is dropped because its instruction is being squashed.
- Counters:
  - `stall_cnt` increments on every stall cycle.
  - `flush_cnt` increments on every taken-branch cycle.
  - Both saturate at all-ones and never wrap.
- When `id_valid`=0, no hazard is raised for the ID slot.

## Timing
- Hazard and forward outputs are combinational from the scoreboard registers plus the ID and branch inputs, in the same cycle. The scoreboard and counters update on the rising edge of `clk`.
- While `rst`=1, outputs are held at these values:
  - `pc_write`=0, `if_id_write`=0
  - `if_id_flush`=1, `id_ex_bubble`=1
  - `fwd_a`=`fwd_b`=00
  - counters 0
  - all scoreboard entries invalid
- In the first cycle after `rst` falls, outputs are normal values computed from the empty scoreboard.
- Reset asserted mid-stall or mid-flush clears everything at the next edge; no pending state survives.
- Stall latency: a load followed immediately by its consumer costs exactly 1 bubble. With a one-instruction gap there is no stall and the value is forwarded via 01.

## Configuration
- `HAZARD_FORWARDING_EN` defined: behaviour as above.
- `HAZARD_FORWARDING_EN` undefined:
  - `fwd_a`/`fwd_b` are tied to 00 and the forwarding logic is removed.
  - The stall condition becomes: the ID instruction matches any of `sb_ex`, `sb_mem` or `sb_wb`. The register bank is not write-through.
  - Consequently a dependent instruction stalls 3, 2 or 1 cycles depending on its distance from the producer.
  - Branch priority and the counters are unchanged.

## Structure
- Shared package `hazard_pkg` holds:
  - `sb_entry_t` (packed struct)
  - `fwd_sel_t` enum: `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10
  - localparam `REG_ZERO`=5'd0
- Sub-module `fwd_select`: a combinational compare of one source register against the `sb_mem`/`sb_wb` entries, returning `fwd_sel_t`. It is instantiated twice, for A and B.

## Test plan
- Reset held 3 cycles → `pc_write`=0, `if_id_flush`=1, `id_ex_bubble`=1, counters 0. On release, `pc_write`=1, `if_id_write`=1, `fwd_a`=`fwd_b`=00.
- `ld x5,0(x1)` then `add x6,x5,x2` → exactly one cycle of `pc_write`=0 / `id_ex_bubble`=1. Next cycle, with `add` in EX, `fwd_a`=01. `stall_cnt`=1.
- `add x3,x1,x2` then `sub x4,x3,x3` → no stall; with `sub` in EX, `fwd_a`=`fwd_b`=10. Repeat with one NOP between them → 01.
- `addi x0,x0,1` then `add x7,x0,x0` → no stall, forwards 00.
- Load-use stall coinciding with `ex_branch_taken`=1 → `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=1, `stall_cnt` unchanged, `flush_cnt`+1.
- `HAZARD_FORWARDING_EN` off: `add x3,..` followed by consumer of x3 → 3 stall cycles, forwards 00. Separately, force counters near max → they stay at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry,
// forwarding select encoding and the producer/consumer match helper.
package hazard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic       reg_write;
        logic       mem_read;
    } sb_entry_t;

    // True when producer p writes the register that a consumer actually reads.
    // x0 is never a producer.
    function automatic logic sb_hit(
        input sb_entry_t  p,
        input logic [4:0] src,
        input logic       use_src
    );
        return p.valid && p.reg_write && (p.rd != REG_ZERO) &&
               use_src && (p.rd == src);
    endfunction

endpackage

// File: rtl/hazard_controller_fwd_select.sv
// Operand forwarding select for one EX source register.
// Ports: src/use_src (EX source), sb_mem/sb_wb (producers), sel (fwd_sel_t).
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  sb_entry_t  sb_mem,
    input  sb_entry_t  sb_wb,
    output fwd_sel_t   sel
);

    // Only the producer-side fields take part in the compare.
    logic unused_fields;
    assign unused_fields = ^{sb_mem.rs1, sb_mem.rs2, sb_mem.use_rs1,
                             sb_mem.use_rs2, sb_mem.mem_read,
                             sb_wb.rs1, sb_wb.rs2, sb_wb.use_rs1,
                             sb_wb.use_rs2, sb_wb.mem_read};

    // MEM holds the youngest producer, so it wins over WB.
    always_comb begin
        sel = FWD_RF;
        if (sb_hit(sb_mem, src, use_src)) begin
            sel = FWD_MEM;
        end else if (sb_hit(sb_wb, src, use_src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stall/flush/bubble control, EX operand
// forwarding from a shadow EX/MEM/WB scoreboard, saturating perf counters.
// Ports: clk, rst (sync, active high); id_* decode fields of the ID slot;
// ex_branch_taken; pc_write, if_id_write, if_id_flush, id_ex_bubble;
// fwd_a/fwd_b (00 RF, 10 EX/MEM, 01 MEM/WB); stall_cnt, flush_cnt.
// Build option: HAZARD_FORWARDING_EN enables forwarding; without it every
// in-flight producer stalls the consumer and fwd_a/fwd_b stay 00.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_entry_t        sb_ex;
    sb_entry_t        sb_mem;
    sb_entry_t        sb_wb;
    sb_entry_t        id_entry;
    logic             hit_ex;
    logic             hit_mem;
    logic             hit_wb;
    logic             stall_req;
    logic             stall_ev;
    logic             flush_ev;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Fields kept in the entries for symmetry but not read in every build.
    logic unused_sb;
    assign unused_sb = ^{sb_ex, sb_mem, sb_wb};

    // An empty ID slot enters the scoreboard as an all-zero entry.
    always_comb begin
        id_entry = '0;
        if (id_valid) begin
            id_entry.valid     = 1'b1;
            id_entry.rd        = id_rd;
            id_entry.rs1       = id_rs1;
            id_entry.rs2       = id_rs2;
            id_entry.use_rs1   = id_use_rs1;
            id_entry.use_rs2   = id_use_rs2;
            id_entry.reg_write = id_reg_write;
            id_entry.mem_read  = id_mem_read;
        end
    end

    assign hit_ex  = sb_hit(sb_ex, id_rs1, id_use_rs1) |
                     sb_hit(sb_ex, id_rs2, id_use_rs2);
    assign hit_mem = sb_hit(sb_mem, id_rs1, id_use_rs1) |
                     sb_hit(sb_mem, id_rs2, id_use_rs2);
    assign hit_wb  = sb_hit(sb_wb, id_rs1, id_use_rs1) |
                     sb_hit(sb_wb, id_rs2, id_use_rs2);

`ifdef HAZARD_FORWARDING_EN
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;
    logic     unused_hits;

    // Only a load in EX cannot be forwarded in time.
    assign stall_req   = id_valid & hit_ex & sb_ex.mem_read;
    assign unused_hits = hit_mem ^ hit_wb;

    fwd_select u_fwd_a (
        .src     (sb_ex.rs1),
        .use_src (sb_ex.use_rs1),
        .sb_mem  (sb_mem),
        .sb_wb   (sb_wb),
        .sel     (sel_a)
    );

    fwd_select u_fwd_b (
        .src     (sb_ex.rs2),
        .use_src (sb_ex.use_rs2),
        .sb_mem  (sb_mem),
        .sb_wb   (sb_wb),
        .sel     (sel_b)
    );

    assign fwd_a = rst ? FWD_RF : sel_a;
    assign fwd_b = rst ? FWD_RF : sel_b;
`else
    // Register file is not write-through: wait until the producer retires.
    assign stall_req = id_valid & (hit_ex | hit_mem | hit_wb);
    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
`endif

    // A taken branch squashes the ID instruction, so its stall is dropped.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        priority case (1'b1)
            rst: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ex_branch_taken: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            stall_req: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign stall_ev = stall_req & ~ex_branch_taken & ~rst;
    assign flush_ev = ex_branch_taken & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_ex   <= '0;
            sb_mem  <= '0;
            sb_wb   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= id_ex_bubble ? '0 : id_entry;
            if (stall_ev && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_ev && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt = rst ? '0 : stall_q;
    assign flush_cnt = rst ? '0 : flush_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed pipeline scenarios
// plus random decode/branch traffic against an in-order pipeline model.
module tb_hazard_controller;

    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit       rw;
        bit       mr;
    } ins_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [4:0]    id_rs1 = '0;
    logic [4:0]    id_rs2 = '0;
    logic          id_use_rs1 = 1'b0;
    logic          id_use_rs2 = 1'b0;
    logic [4:0]    id_rd = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    hazard_controller #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ins_t pipe [3];
    int   m_sc = 0;
    int   m_fc = 0;
    bit   last_stall;
    int   o_pc, o_ifw, o_fl, o_bub, o_fa, o_fb, o_sc, o_fc;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(input int rd, input int rs1, input int rs2,
                                input bit u1, input bit u2,
                                input bit rw, input bit mr);
        ins_t i;
        i.v = 1'b1;
        i.rd = rd[4:0];
        i.rs1 = rs1[4:0];
        i.rs2 = rs2[4:0];
        i.u1 = u1;
        i.u2 = u2;
        i.rw = rw;
        i.mr = mr;
        return i;
    endfunction

    function automatic bit writes(input ins_t p, input bit [4:0] r,
                                  input bit u);
        return p.v && p.rw && (p.rd != 0) && u && (p.rd == r);
    endfunction

    function automatic bit dep(input ins_t p, input ins_t c);
        return writes(p, c.rs1, c.u1) || writes(p, c.rs2, c.u2);
    endfunction

    // Youngest in-flight producer past EX supplies the operand.
    function automatic int src_of(input bit [4:0] r, input bit u);
        if (writes(pipe[1], r, u)) return 2;
        if (writes(pipe[2], r, u)) return 1;
        return 0;
    endfunction

    task automatic step(input ins_t i, input bit br, input bit r);
        bit stall;
        int e_pc, e_ifw, e_fl, e_bub, e_fa, e_fb;
        rst = r;
        id_valid = i.v;
        id_rd = i.rd;
        id_rs1 = i.rs1;
        id_rs2 = i.rs2;
        id_use_rs1 = i.u1;
        id_use_rs2 = i.u2;
        id_reg_write = i.rw;
        id_mem_read = i.mr;
        ex_branch_taken = br;
        @(negedge clk);
        if (FWD_ON)
            stall = i.v && dep(pipe[0], i) && pipe[0].mr;
        else
            stall = i.v && (dep(pipe[0], i) || dep(pipe[1], i) ||
                            dep(pipe[2], i));
        if (r) begin
            e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
        end else if (br) begin
            e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
        end else if (stall) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
        end
        e_fa = 0;
        e_fb = 0;
        if (FWD_ON && !r && pipe[0].v) begin
            e_fa = src_of(pipe[0].rs1, pipe[0].u1);
            e_fb = src_of(pipe[0].rs2, pipe[0].u2);
        end
        o_pc = int'(pc_write);
        o_ifw = int'(if_id_write);
        o_fl = int'(if_id_flush);
        o_bub = int'(id_ex_bubble);
        o_fa = int'(fwd_a);
        o_fb = int'(fwd_b);
        o_sc = int'(stall_cnt);
        o_fc = int'(flush_cnt);
        chk("pc_write", o_pc, e_pc);
        chk("if_id_write", o_ifw, e_ifw);
        chk("if_id_flush", o_fl, e_fl);
        chk("id_ex_bubble", o_bub, e_bub);
        chk("fwd_a", o_fa, e_fa);
        chk("fwd_b", o_fb, e_fb);
        chk("stall_cnt", o_sc, r ? 0 : m_sc);
        chk("flush_cnt", o_fc, r ? 0 : m_fc);
        last_stall = stall && !br && !r;
        @(posedge clk);
        if (r) begin
            pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (br && m_fc < CMAX) m_fc++;
            if (last_stall && m_sc < CMAX) m_sc++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (e_bub == 1 || !i.v) ? ins_t'(0) : i;
        end
        #1;
    endtask

    // Present one instruction until it leaves ID; return stall cycles.
    task automatic issue(input ins_t i, output int n);
        n = 0;
        step(i, 1'b0, 1'b0);
        while (last_stall && n < 8) begin
            n++;
            step(i, 1'b0, 1'b0);
        end
    endtask

    initial begin
        ins_t nop, idle, ld5, add6, add3, sub4, addi0, add7, rnd;
        int   n, sc0, fc0;
        nop   = mk(0, 0, 0, 1, 0, 1, 0);
        idle  = '0;
        ld5   = mk(5, 1, 0, 1, 0, 1, 1);
        add6  = mk(6, 5, 2, 1, 1, 1, 0);
        add3  = mk(3, 1, 2, 1, 1, 1, 0);
        sub4  = mk(4, 3, 3, 1, 1, 1, 0);
        addi0 = mk(0, 0, 0, 1, 0, 1, 0);
        add7  = mk(7, 0, 0, 1, 1, 1, 0);

        repeat (3) step(idle, 1'b0, 1'b1);
        step(nop, 1'b0, 1'b0);
        chk("release_pc", o_pc, 1);
        chk("release_ifw", o_ifw, 1);
        chk("release_fwd", o_fa + o_fb, 0);

        issue(ld5, n);
        issue(add6, n);
        chk("load_use_stalls", n, FWD_ON ? 1 : 3);
        step(nop, 1'b0, 1'b0);
        chk("load_use_fwd_a", o_fa, FWD_ON ? 1 : 0);
        chk("load_use_stall_cnt", o_sc, FWD_ON ? 1 : 3);

        repeat (3) step(nop, 1'b0, 1'b0);
        issue(add3, n);
        issue(sub4, n);
        chk("alu_back_to_back", n, FWD_ON ? 0 : 3);
        step(nop, 1'b0, 1'b0);
        chk("mem_fwd_a", o_fa, FWD_ON ? 2 : 0);
        chk("mem_fwd_b", o_fb, FWD_ON ? 2 : 0);

        repeat (3) step(nop, 1'b0, 1'b0);
        issue(add3, n);
        issue(nop, n);
        issue(sub4, n);
        chk("alu_gap_one", n, FWD_ON ? 0 : 2);
        step(nop, 1'b0, 1'b0);
        chk("wb_fwd_a", o_fa, FWD_ON ? 1 : 0);

        repeat (3) step(nop, 1'b0, 1'b0);
        issue(addi0, n);
        issue(add7, n);
        chk("x0_no_stall", n, 0);
        step(nop, 1'b0, 1'b0);
        chk("x0_no_fwd", o_fa + o_fb, 0);

        repeat (3) step(nop, 1'b0, 1'b0);
        issue(ld5, n);
        sc0 = m_sc;
        fc0 = m_fc;
        step(add6, 1'b1, 1'b0);
        chk("br_flush", o_fl, 1);
        chk("br_bubble", o_bub, 1);
        chk("br_pc", o_pc, 1);
        step(idle, 1'b0, 1'b0);
        chk("br_stall_cnt", o_sc, sc0);
        chk("br_flush_cnt", o_fc, fc0 + 1);

        issue(ld5, n);
        step(add6, 1'b0, 1'b1);
        step(idle, 1'b0, 1'b1);
        step(add6, 1'b0, 1'b0);
        chk("rst_mid_pc", o_pc, 1);
        chk("rst_mid_stall_cnt", o_sc, 0);
        chk("rst_mid_flush_cnt", o_fc, 0);

        for (int k = 0; k < 400; k++) begin
            rnd.v   = ($urandom_range(0, 7) != 0);
            rnd.rd  = 5'($urandom_range(0, 3));
            rnd.rs1 = 5'($urandom_range(0, 3));
            rnd.rs2 = 5'($urandom_range(0, 3));
            rnd.u1  = 1'($urandom);
            rnd.u2  = 1'($urandom);
            rnd.rw  = 1'($urandom);
            rnd.mr  = 1'($urandom);
            step(rnd, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 99) == 0);
        end

        step(idle, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            step(ld5, 1'b0, 1'b0);
            step(add6, 1'b0, 1'b0);
            step(nop, 1'b1, 1'b0);
        end
        step(idle, 1'b0, 1'b0);
        chk("sat_stall_cnt", o_sc, CMAX);
        chk("sat_flush_cnt", o_fc, CMAX);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
